nibble_serial_adder: RTL
========================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter NIBBLES, default 4, SHALL set the number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..16.
REQ-002 Clock  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 ResetN  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of Clock.
REQ-004 InputValid  input  1  SHALL indicate that InputA, InputB and InputCarry hold a valid operation.
REQ-005 InputReady  output  1  SHALL indicate that the block can accept an operation this cycle.
REQ-006 InputA  input  W  SHALL carry the first unsigned/two's-complement operand.
REQ-007 InputB  input  W  SHALL carry the second operand.
REQ-008 InputCarry  input  1  SHALL carry the carry-in to nibble 0.
REQ-009 OutputValid  output  1  SHALL indicate that SumOut, CarryOut and Overflow hold a completed result.
REQ-010 OutputReady  input  1  SHALL indicate that the consumer takes the result this cycle.
REQ-011 SumOut  output  W  SHALL carry the result A+B+Cin mod 2^W.
REQ-012 CarryOut  output  1  SHALL carry the carry out of nibble NIBBLES-1.
REQ-013 Overflow  output  1  SHALL carry signed overflow: carry into bit W-1 XOR carry out of bit W-1.

Function
REQ-014 The block SHALL implement a 3-state FSM: IDLE, ADD, DONE.
REQ-015 InputReady SHALL equal (state == IDLE), combinationally; all other outputs SHALL be registered.
REQ-016 Accept: in IDLE, InputValid=1 at an edge SHALL latch InputA, InputB, carry register <= InputCarry, nibble index <= 0, and move to ADD; InputValid=0 SHALL keep IDLE.
REQ-017 ADD: each edge SHALL compute a 4-bit carry-lookahead add of A[4i+3:4i], B[4i+3:4i] and the carry register, write the 4-bit sum into result bits [4i+3:4i], load the carry register with the nibble carry-out, and increment i.
REQ-018 On the ADD edge with i == NIBBLES-1, the block SHALL load CarryOut with the nibble carry-out, Overflow with (carry into nibble bit 3) XOR (nibble carry-out), set OutputValid=1 and move to DONE.
REQ-019 Latency: OutputValid SHALL be high exactly NIBBLES cycles after the accept edge (NIBBLES ADD edges, no idle bubbles).
REQ-020 DONE: SumOut, CarryOut, Overflow and OutputValid SHALL hold stable while OutputReady=0.
REQ-021 DONE with OutputReady=1 at an edge SHALL clear OutputValid and move to IDLE; SumOut/CarryOut/Overflow SHALL retain their values until the next accept.
REQ-022 InputValid SHALL be ignored in ADD and DONE; no operation is queued (throughput one operation per NIBBLES+2 cycles minimum).
REQ-023 OutputReady SHALL be ignored outside DONE.
REQ-024 At accept, the result register SHALL clear to 0 so no stale nibbles leak into SumOut.
REQ-025 Nibble index SHALL be ceil(log2(NIBBLES)) bits wide and SHALL never wrap past NIBBLES-1 in ADD.

Reset
REQ-026 ResetN=0 at an edge SHALL force state IDLE, index 0, carry register 0, SumOut 0, CarryOut 0, Overflow 0, OutputValid 0, and InputReady SHALL read 1 the cycle after.
REQ-027 ResetN=0 SHALL take priority over every handshake, including mid-ADD and DONE; the in-flight operation SHALL be discarded with no OutputValid pulse.
REQ-028 Simultaneous ResetN=0 and InputValid=1 SHALL NOT accept the operation.

Verification (NIBBLES=4)
REQ-029 A=0x1234, B=0x4321, Cin=0 -> SumOut=0x5555, CarryOut=0, Overflow=0; OutputValid high 4 cycles after accept.
REQ-030 A=0xFFFF, B=0x0000, Cin=1 -> SumOut=0x0000, CarryOut=1, Overflow=0 (carry ripples through all four nibbles).
REQ-031 A=0x7FFF, B=0x0001, Cin=0 -> SumOut=0x8000, CarryOut=0, Overflow=1; A=0x8000, B=0x8000 -> SumOut=0x0000, CarryOut=1, Overflow=1.
REQ-032 Backpressure: hold OutputReady=0 for 3 cycles in DONE while driving InputValid=1 with new operands -> outputs unchanged, InputReady=0, new operands not accepted; OutputReady=1 -> IDLE next cycle, then the new operation is accepted.
REQ-033 Reset mid-operation: ResetN=0 on the 3rd ADD edge -> next cycle IDLE, InputReady=1, OutputValid=0, SumOut=0x0000; no OutputValid pulse for the aborted operation.
REQ-034 Back-to-back: two operations driven with InputValid held high -> second accepted on the edge after the first result handshake, results both correct.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Bit-serial-by-nibble adder: one 4-bit carry-lookahead slice per clock, NIBBLES cycles per add,
// with a valid/ready handshake on both the operand and the result side.
module nibble_serial_adder #(
    parameter int NIBBLES = 4,
    localparam int W      = 4 * NIBBLES,
    localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic         Clock,
    input  logic         ResetN,
    input  logic         InputValid,
    output logic         InputReady,
    input  logic [W-1:0] InputA,
    input  logic [W-1:0] InputB,
    input  logic         InputCarry,
    output logic         OutputValid,
    input  logic         OutputReady,
    output logic [W-1:0] SumOut,
    output logic         CarryOut,
    output logic         Overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [5:0]       nib_res;
    logic             last;
    logic             accept;

    // Returns {carry into bit 3, carry out, sum[3:0]} of a 4-bit lookahead add.
    function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[3], c[4], p ^ c[3:0]};
    endfunction

    assign InputReady = (state == IDLE);
    assign accept     = InputReady && InputValid;
    assign last       = (idx == IDX_W'(NIBBLES - 1));

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IDX_W'(n)) begin
                nib_a = a_reg[4*n +: 4];
                nib_b = b_reg[4*n +: 4];
            end
        end
        nib_res = cla4(nib_a, nib_b, carry);
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (InputValid)  next_state = ADD;
            ADD:     if (last)        next_state = DONE;
            DONE:    if (OutputReady) next_state = IDLE;
            default:                  next_state = IDLE;
        endcase
    end

    // Operand capture: pure data, no reset needed.
    always_ff @(posedge Clock) begin
        if (accept) begin
            a_reg <= InputA;
            b_reg <= InputB;
        end
    end

    // Nibble datapath and registered result/handshake outputs.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            carry       <= 1'b0;
            idx         <= '0;
            SumOut      <= '0;
            CarryOut    <= 1'b0;
            Overflow    <= 1'b0;
            OutputValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InputValid) begin
                        carry  <= InputCarry;
                        idx    <= '0;
                        SumOut <= '0;
                    end
                end
                ADD: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (idx == IDX_W'(n)) SumOut[4*n +: 4] <= nib_res[3:0];
                    end
                    carry <= nib_res[4];
                    if (last) begin
                        CarryOut    <= nib_res[4];
                        Overflow    <= nib_res[5] ^ nib_res[4];
                        OutputValid <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (OutputReady) OutputValid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
